// File: rtl/hub_pkg.sv
// Shared definitions for hub bus initiators: size codes, initiator states and slot count.
package hub_pkg;

  localparam int HUB_SLOTS = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } hub_state_e;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/hub_lane.sv
// Combinational hub lane logic: byte enables and write-data replication from size/address,
// plus zero-extended extraction of the addressed lane from a read long.
module hub_lane
  import hub_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wb_o,
  output logic [31:0] d_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    wb_o    = 4'b0000;
    d_o     = '0;
    rdata_o = '0;
    case (size_i)
      SZ_BYTE: begin
        wb_o    = 4'b0001 << addr_lo_i;
        d_o     = {4{wdata_i[7:0]}};
        rdata_o = {24'b0, rdata_i[{addr_lo_i, 3'b000} +: 8]};
      end
      SZ_WORD: begin
        wb_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        d_o     = {2{wdata_i[15:0]}};
        rdata_o = {16'b0, (addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0])};
      end
      // SZ_LONG and the unused code 2'b11 both move the full long.
      default: begin
        wb_o    = 4'b1111;
        d_o     = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/hub_client.sv
// Cog-side hub bus initiator: accept one request, wait for this cog's slot, drive the bus, return read data.
// Optional wait-statistics counter is built when HUB_WAIT_STATS_EN is defined.
module hub_client
  import hub_pkg::*;
#(
  parameter int COG_ID = 0
) (
  input  logic        clk_cog,
  input  logic        res,
  input  logic        ena_bus,
  input  logic [2:0]  hub_slot,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_data,
  output logic        bus_req,
  output logic        bus_w,
  output logic [3:0]  bus_wb,
  output logic [13:0] bus_a,
  output logic [31:0] bus_d,
  input  logic [31:0] bus_q,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  wait_cycles
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so the requester holds req_valid until then.
  localparam logic [2:0] SLOT = 3'(COG_ID % HUB_SLOTS);

  hub_state_e  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_w_q, bus_w_d;
  logic [3:0]  bus_wb_q, bus_wb_d;
  logic [13:0] bus_a_q, bus_a_d;
  logic [31:0] bus_d_q, bus_d_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  alo_q, alo_d;

  logic        grant;
  logic        accept;
  logic        lane_sel_req;
  logic [1:0]  lane_size;
  logic [1:0]  lane_alo;
  logic [3:0]  lane_wb;
  logic [31:0] lane_d;
  logic [31:0] lane_rdata;

  assign grant  = ena_bus && (hub_slot == SLOT);
  assign accept = (state_q == IDLE) && req_valid;

  // One lane unit serves both directions: live request fields in IDLE, latched fields otherwise.
  assign lane_sel_req = (state_q == IDLE);
  assign lane_size    = lane_sel_req ? req_size : size_q;
  assign lane_alo     = lane_sel_req ? req_addr[1:0] : alo_q;

  hub_lane u_lane (
    .size_i    (lane_size),
    .addr_lo_i (lane_alo),
    .wdata_i   (req_data),
    .rdata_i   (bus_q),
    .wb_o      (lane_wb),
    .d_o       (lane_d),
    .rdata_o   (lane_rdata)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_w_d     = bus_w_q;
    bus_wb_d    = bus_wb_q;
    bus_a_d     = bus_a_q;
    bus_d_d     = bus_d_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    wr_d        = wr_q;
    size_d      = size_q;
    alo_d       = alo_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          bus_req_d = 1'b1;
          bus_w_d   = req_wr;
          bus_wb_d  = req_wr ? lane_wb : 4'b0000;
          bus_a_d   = req_addr[15:2];
          bus_d_d   = req_wr ? lane_d : 32'h0;
          wr_d      = req_wr;
          size_d    = req_size;
          alo_d     = req_addr[1:0];
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (grant) begin
          bus_req_d = 1'b0;
          bus_w_d   = 1'b0;
          state_d   = CAPT;
        end
      end
      // Memory registered bus_q on the grant edge, so it is valid throughout CAPT.
      CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = wr_q ? 32'h0 : lane_rdata;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_w_q     <= 1'b0;
      bus_wb_q    <= 4'b0000;
      bus_a_q     <= '0;
      bus_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wr_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      alo_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_w_q     <= bus_w_d;
      bus_wb_q    <= bus_wb_d;
      bus_a_q     <= bus_a_d;
      bus_d_q     <= bus_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      alo_q       <= alo_d;
    end
  end

`ifdef HUB_WAIT_STATS_EN
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] wait_q, wait_d;

  // The grant edge is itself a WAIT clock, so the loaded value includes it.
  always_comb begin
    cnt_d  = cnt_q;
    wait_d = wait_q;
    if (accept) begin
      cnt_d = 5'd0;
    end else if (state_q == WAIT) begin
      cnt_d = sat_inc5(cnt_q);
      if (grant) wait_d = sat_inc5(cnt_q);
    end
  end

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      cnt_q  <= 5'd0;
      wait_q <= 5'd0;
    end else begin
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
    end
  end

  assign wait_cycles = wait_q;
`else
  assign wait_cycles = 5'd0;
`endif

  assign req_ready = (state_q == IDLE);
  assign bus_req   = bus_req_q;
  assign bus_w     = bus_w_q;
  assign bus_wb    = bus_wb_q;
  assign bus_a     = bus_a_q;
  assign bus_d     = bus_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_hub_client.sv
// Bench for hub_client (COG_ID=3): directed scenarios plus randomized transactions against a lane-arithmetic model.
module tb_hub_client;

  localparam int COG = 3;

  logic        clk_cog = 1'b0;
  logic        res = 1'b1;
  logic        ena_bus = 1'b0;
  logic [2:0]  hub_slot = 3'd0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_data = 32'h0;
  logic        bus_req;
  logic        bus_w;
  logic [3:0]  bus_wb;
  logic [13:0] bus_a;
  logic [31:0] bus_d;
  logic [31:0] bus_q = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  wait_cycles;

  hub_client #(.COG_ID(COG)) dut (
    .clk_cog     (clk_cog),
    .res         (res),
    .ena_bus     (ena_bus),
    .hub_slot    (hub_slot),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_size    (req_size),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .bus_req     (bus_req),
    .bus_w       (bus_w),
    .bus_wb      (bus_wb),
    .bus_a       (bus_a),
    .bus_d       (bus_d),
    .bus_q       (bus_q),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .wait_cycles (wait_cycles)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_cog = ~clk_cog;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_wait = 32'h0;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [15:0] m_addr;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lane_bytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  // Byte enables: 'lane_bytes' ones starting at the size-aligned byte offset.
  function automatic logic [31:0] m_wb(input logic wr, input logic [1:0] size, input logic [15:0] addr);
    int n, off;
    if (!wr) return 32'h0;
    n   = lane_bytes(size);
    off = (int'(addr) % 4) / n * n;
    return 32'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_dval(input logic [1:0] size, input logic [31:0] data);
    int n;
    n = lane_bytes(size);
    if (n == 1) return data[7:0] * 32'h0101_0101;
    if (n == 2) return data[15:0] * 32'h0001_0001;
    return data;
  endfunction

  function automatic logic [31:0] m_rsp(input logic wr, input logic [1:0] size,
                                        input logic [15:0] addr, input logic [31:0] q);
    int n, off;
    longint mask;
    if (wr) return 32'h0;
    n    = lane_bytes(size);
    off  = (int'(addr) % 4) / n * n;
    mask = (64'd1 << (8 * n)) - 1;
    return 32'((longint'(q) >> (8 * off)) & mask);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_cog);
  endtask

  task automatic set_req(input logic wr, input logic [1:0] size, input logic [15:0] addr,
                         input logic [31:0] data);
    req_wr    = wr;
    req_size  = size;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    m_wr = wr; m_size = size; m_addr = addr; m_data = data;
  endtask

  task automatic accept();
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    req_data  = $urandom;
    chk("bus_req_after_accept", 32'(bus_req), 32'd1);
    chk("ready_low_in_wait", 32'(req_ready), 32'd0);
    chk("bus_a", 32'(bus_a), 32'(m_addr >> 2));
    chk("bus_w", 32'(bus_w), 32'(m_wr));
    chk("bus_wb", 32'(bus_wb), m_wb(m_wr, m_size, m_addr));
    if (m_wr) chk("bus_d", bus_d, m_dval(m_size, m_data));
  endtask

  // Drive 'k-1' non-granting clocks then a grant; 'prior' counts wait clocks already spent.
  task automatic grant_after(input int k, input logic [31:0] q, input int prior);
    int s;
    for (int i = 1; i < k; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          s = $urandom_range(0, 6);
          if (s >= COG) s++;
          ena_bus = 1'b1; hub_slot = 3'(s);
        end
        1: begin ena_bus = 1'b0; hub_slot = 3'(COG); end
        default: begin ena_bus = 1'b0; hub_slot = 3'($urandom_range(0, 7)); end
      endcase
      step();
      chk("bus_req_held", 32'(bus_req), 32'd1);
    end
    ena_bus  = 1'b1;
    hub_slot = 3'(COG);
    step();
    ena_bus  = 1'b0;
    hub_slot = 3'($urandom_range(0, 7));
    bus_q    = q;
    chk("bus_req_after_grant", 32'(bus_req), 32'd0);
    chk("bus_w_after_grant", 32'(bus_w), 32'd0);
    chk("no_rsp_in_capt", 32'(rsp_valid), 32'd0);
    exp_q.push_back(m_rsp(m_wr, m_size, m_addr, q));
`ifdef HUB_WAIT_STATS_EN
    exp_wait = (k + prior > 31) ? 32'd31 : 32'(k + prior);
`else
    exp_wait = 32'd0;
`endif
  endtask

  task automatic capture();
    logic [31:0] e;
    step();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ready_in_rsp_cycle", 32'(req_ready), 32'd1);
    chk("wait_cycles", 32'(wait_cycles), exp_wait);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=rsp expected=none");
    end else begin
      e = exp_q.pop_front();
      chk("rsp_data", rsp_data, e);
    end
  endtask

  task automatic idle_check();
    step();
    chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_bus_w"}, 32'(bus_w), 32'd0);
    chk({tag, "_bus_wb"}, 32'(bus_wb), 32'd0);
    chk({tag, "_bus_a"}, 32'(bus_a), 32'd0);
    chk({tag, "_bus_d"}, bus_d, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_wait_cycles"}, 32'(wait_cycles), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    repeat (3) step();
    check_all_zero("reset");
    chk("reset_ready", 32'(req_ready), 32'd1);
    res = 1'b0;
    step();

    // Long read, accepted while slot=5, grant four clocks later.
    hub_slot = 3'd5;
    set_req(1'b0, 2'b10, 16'h0104, 32'h0);
    accept();
    chk("long_read_addr", 32'(bus_a), 32'h0041);
    grant_after(4, 32'hDEAD_BEEF, 0);
    capture();
    idle_check();

    // Byte write $AB to $0007.
    set_req(1'b1, 2'b00, 16'h0007, 32'h0000_00AB);
    accept();
    chk("byte_wr_wb", 32'(bus_wb), 32'b1000);
    chk("byte_wr_d", bus_d, 32'hABAB_ABAB);
    grant_after(2, 32'h5555_AAAA, 0);
    capture();
    idle_check();

    // Word reads: upper half, then addr[0] ignored on the lower half.
    set_req(1'b0, 2'b01, 16'h0006, 32'h0);
    accept();
    grant_after(1, 32'h1234_5678, 0);
    capture();
    chk("word_hi", rsp_data, 32'h0000_1234);
    set_req(1'b0, 2'b01, 16'h0005, 32'h0);
    accept();
    grant_after(3, 32'h1234_5678, 0);
    capture();
    chk("word_lo", rsp_data, 32'h0000_5678);
    idle_check();

    // Slot match without ena_bus, then ena_bus on a foreign slot: no grant.
    set_req(1'b0, 2'b00, 16'h0102, 32'h0);
    accept();
    ena_bus = 1'b0; hub_slot = 3'(COG);
    step();
    chk("no_grant_slot_only", 32'(bus_req), 32'd1);
    ena_bus = 1'b1; hub_slot = 3'd2;
    step();
    chk("no_grant_ena_only", 32'(bus_req), 32'd1);
    grant_after(1, 32'hCAFE_F00D, 2);
    capture();
    chk("byte_lane2", rsp_data, 32'h0000_00FE);
    idle_check();

    // Reset during WAIT: outputs clear at once, request is dropped.
    set_req(1'b1, 2'b10, 16'h0200, 32'h1111_2222);
    accept();
    ena_bus = 1'b0;
    step();
    step();
    res = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    res = 1'b0;
    exp_wait = 32'd0;
    ena_bus = 1'b1; hub_slot = 3'(COG);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
      chk("dropped_no_req", 32'(bus_req), 32'd0);
    end
    ena_bus = 1'b0;
    set_req(1'b0, 2'b10, 16'h0300, 32'h0);
    accept();
    grant_after(2, 32'h0BAD_F00D, 0);
    capture();
    idle_check();

    // Back-to-back: second request held through the first completion.
    set_req(1'b0, 2'b00, 16'h0011, 32'h0);
    accept();
    grant_after(1, 32'h0102_0304, 0);
    set_req(1'b1, 2'b01, 16'h8002, 32'h0000_BEEF);
    chk("ready_low_in_capt", 32'(req_ready), 32'd0);
    capture();
    chk("b2b_first_data", rsp_data, 32'h0000_0003);
    accept();
    chk("b2b_second_wb", 32'(bus_wb), 32'b1100);
    grant_after(3, 32'hFFFF_FFFF, 0);
    capture();
    idle_check();

    // Long wait exercises counter saturation.
    set_req(1'b0, 2'b11, 16'h0420, 32'h0);
    accept();
    grant_after(40, 32'h7654_3210, 0);
    capture();
    idle_check();

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      set_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              16'($urandom), $urandom);
      accept();
      k = $urandom_range(1, 6);
      grant_after(k, $urandom, 0);
      capture();
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub_client.md
Name: hub_client

Overview:
- Cog-side initiator for the hub memory bus: accepts one byte/word/long read or write request from cog logic.
- Waits for this cog's rotating hub slot, then drives the hub bus (w, wb, a, d).
- For reads, captures the registered hub data one clock after the grant and returns it lane-extracted and zero-extended.
- One instance per cog, between the cog's RDxxxx/WRxxxx sequencing and the hub bus mux.

Parameters:
- COG_ID, 0, 3-bit slot number this instance owns; grant when hub_slot == COG_ID.

Ports:
- clk_cog  in  1  cog clock; all state on its rising edge.
- res  in  1  asynchronous active-high reset.
- ena_bus  in  1  hub bus enable strobe (hub access edge).
- hub_slot  in  3  current hub rotation slot.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept (combinational: state == IDLE).
- req_wr  in  1  1 = write, 0 = read.
- req_size  in  2  00 byte, 01 word, 10 long, 11 treated as long.
- req_addr  in  16  hub byte address.
- req_data  in  32  write data, right-justified.
- bus_req  out  1  high while waiting for slot.
- bus_w  out  1  hub write.
- bus_wb  out  4  byte write enables.
- bus_a  out  14  hub long address.
- bus_d  out  32  lane-replicated write data.
- bus_q  in  32  hub read data, registered by memory on the grant edge.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  zero-extended read data; 0 for writes.
- wait_cycles  out  5  clocks from accept to grant for last access (see Optional Feature).

Behaviour:
- Reset (async, res=1):
  - state=IDLE.
  - bus_req, bus_w, bus_wb, bus_a, bus_d, rsp_valid, rsp_data, wait_cycles all 0.
  - Any in-flight request is dropped silently, no rsp_valid; the write is not performed unless the grant edge already occurred.
- States:
  - IDLE: req_valid && req_ready → register bus outputs, bus_req=1, go WAIT.
  - WAIT: on edge with ena_bus && hub_slot==COG_ID (grant edge) → bus_req=0, bus_w=0, go CAPT.
  - CAPT:
    - next edge → rsp_valid=1, go IDLE.
    - For reads, rsp_data = extract(bus_q); for writes, rsp_data = 0.
    - rsp_valid is cleared on the following edge unless a new completion occurs.
- Bus outputs are registered at accept, so grant is never on the accept edge.
  - Minimum latency: accept→rsp_valid = 3 clocks (accept, grant, capture).
- bus_a = req_addr[15:2].
- wb / d per size:
  - byte: wb = 1<<addr[1:0], d = {4{req_data[7:0]}}.
  - word: wb = addr[1] ? 1100 : 0011, d = {2{req_data[15:0]}}; addr[0] ignored.
  - long: wb = 1111, d = req_data; addr[1:0] ignored.
- Reads drive bus_w=0, bus_wb=0000.
- Extraction (read):
  - byte: lane addr[1:0] zero-extended.
  - word: half addr[1] zero-extended.
  - long: full word.
- Back-to-back: req_ready is high in the same cycle rsp_valid is high; a new accept there is legal.
- req_valid while not IDLE: ignored (req_ready=0); requester must hold.
- ena_bus without slot match, or slot match without ena_bus: no grant.
- Writes to $8000..$FFFF still complete normally with rsp_valid; the memory discards them.

Optional Feature:
- Macro: HUB_WAIT_STATS_EN.
- Defined:
  - A 5-bit counter clears at accept and increments each WAIT clock, saturating at 31.
  - wait_cycles is loaded with the count at the grant edge and held until the next grant.
- Undefined: wait_cycles is tied to 0 and the counter is not built; the port remains.

Decomposition:
- Shared package hub_pkg:
  - size codes SZ_BYTE=2'b00, SZ_WORD=2'b01, SZ_LONG=2'b10.
  - state encoding (IDLE, WAIT, CAPT).
  - HUB_SLOTS=8.
- One sub-module: hub_lane — combinational size/addr → wb, d replication and read extraction; reused by other hub initiators.

Test Plan:
- COG_ID=3; long read $0104 accepted while slot=5; ena_bus with slot=3 four clocks later, bus_q=$DEADBEEF → bus_a=$0041; rsp_valid one clock after grant; rsp_data=$DEADBEEF; wait_cycles=4 if enabled.
- Byte write $AB to $0007 → bus_w=1, bus_wb=1000, bus_d=$ABABABAB, bus_a=$0001; rsp_valid; rsp_data=0.
- Word read $0006 with bus_q=$12345678 → rsp_data=$00001234; word read $0005 → rsp_data=$00005678 (addr[0] ignored).
- Slot match without ena_bus, then ena_bus with slot≠COG_ID → no grant, bus_req stays 1; next true grant completes normally.
- res asserted in WAIT → all outputs 0 immediately, no rsp_valid; new request after release completes normally.
- Back-to-back: second req_valid held high during first completion → accepted in the rsp_valid cycle; two rsp_valid pulses with correct data each.
